// File: rtl/mtf_add_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mtf_add_fifo
// Brief    : Transmit-side add-bus buffer. Admits whole packets from a bus
//            with no backpressure into a packet-aware FIFO. Drops and counts
//            any packet that cannot fit entirely. Forwards stored words to
//            the fabric under one-word-per-credit flow control.
// Revision : 1.0 - initial release
// ============================================================================
module mtf_add_fifo #(
    parameter int DEPTH   = 16,
    parameter int MAX_PKT = 8,
    parameter int CREDITS = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [79:0]      msf_mtf_fabbus80,
    output logic [79:0]      mtf_fab_bus80,
    input  logic             fab_mtf_crd_rtn,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] mtf_drop_cnt,
    output logic             mtf_ovf_err,
    output logic             mtf_frm_err,
    output logic             mtf_crd_err
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_OW = c_AW + 1;
    localparam int c_CW = $clog2(CREDITS + 1);
    localparam int c_WW = $clog2(MAX_PKT + 1);

    localparam logic [c_OW-1:0] c_DEPTH   = c_OW'(DEPTH);
    localparam logic [c_OW-1:0] c_MAX_PKT = c_OW'(MAX_PKT);
    localparam logic [c_CW-1:0] c_CREDITS = c_CW'(CREDITS);
    localparam logic [c_WW-1:0] c_PKT_LIM = c_WW'(MAX_PKT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [78:0]       r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_OW-1:0]   r_occ;
    logic [c_CW-1:0]   r_credits;
    logic [c_WW-1:0]   r_wcnt;
    logic [c_WW-1:0]   w_wcnt_nxt;
    logic [79:0]       r_fab_bus;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic              r_ovf_err;
    logic              r_frm_err;
    logic              r_crd_err;

    logic              w_vld;
    logic              w_sop;
    logic              w_eop;
    logic [c_OW-1:0]   w_free;
    logic              w_room;
    logic              w_wr_en;
    logic              w_pop;
    logic              w_drop_evt;
    logic              w_ovf_evt;
    logic              w_frm_evt;
    logic              w_crd_evt;

    assign w_vld = msf_mtf_fabbus80[79];
    assign w_sop = msf_mtf_fabbus80[78];
    assign w_eop = msf_mtf_fabbus80[77];

    // Free space is taken from the registered occupancy, so a pop in the
    // same cycle never helps the admission check.
    assign w_free = c_DEPTH - r_occ;
    assign w_room = (w_free >= c_MAX_PKT);

    // Pop is gated by credits, so the credit counter can never underflow.
    assign w_pop     = (r_occ != '0) && (r_credits != '0);
    assign w_crd_evt = fab_mtf_crd_rtn && !w_pop && (r_credits == c_CREDITS);

    // Write-side packet FSM: next state, write enable and error events.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wcnt_nxt  = r_wcnt;
        w_drop_evt  = 1'b0;
        w_ovf_evt   = 1'b0;
        w_frm_evt   = 1'b0;
        if (w_vld) begin
            if (w_sop) begin
                // A sop always starts a new packet. Inside an open packet it
                // is a framing error, but the earlier fragment stays queued.
                if (r_state != ST_IDLE) begin
                    w_frm_evt = 1'b1;
                end
                if (w_room) begin
                    w_wr_en     = 1'b1;
                    w_wcnt_nxt  = c_WW'(1);
                    w_state_nxt = w_eop ? ST_IDLE : ST_PKT;
                end else begin
                    w_drop_evt  = 1'b1;
                    w_wcnt_nxt  = '0;
                    w_state_nxt = w_eop ? ST_IDLE : ST_DROP;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_frm_evt = 1'b1;
                    end
                    ST_PKT: begin
                        if (r_wcnt >= c_PKT_LIM) begin
                            // Oversized packet: keep what is already queued
                            // and discard the remainder. An eop on this word
                            // closes the packet immediately.
                            w_ovf_evt   = 1'b1;
                            w_state_nxt = w_eop ? ST_IDLE : ST_DROP;
                        end else begin
                            // Admission reserved MAX_PKT slots, so the FIFO
                            // cannot be full here; the guard only protects
                            // the pointers.
                            w_wr_en    = (r_occ != c_DEPTH);
                            w_wcnt_nxt = r_wcnt + c_WW'(1);
                            if (w_eop) begin
                                w_state_nxt = ST_IDLE;
                            end
                        end
                    end
                    ST_DROP: begin
                        if (w_eop) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // FSM state and per-packet word counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // FIFO storage. The valid bit is implied by occupancy and is not stored.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= msf_mtf_fabbus80[78:0];
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_wr_en && !w_pop) begin
                r_occ <= r_occ + c_OW'(1);
            end else if (!w_wr_en && w_pop) begin
                r_occ <= r_occ - c_OW'(1);
            end
        end
    end

    // Output register. An idle cycle clears only the valid bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fab_bus <= '0;
        end else if (w_pop) begin
            r_fab_bus <= {1'b1, r_mem[r_rd_ptr]};
        end else begin
            r_fab_bus[79] <= 1'b0;
        end
    end

    // Credit counter. A pop and a return in the same cycle cancel out, and a
    // return to a full counter is held as an error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_credits <= c_CREDITS;
        end else if (w_pop && !fab_mtf_crd_rtn) begin
            r_credits <= r_credits - c_CW'(1);
        end else if (!w_pop && fab_mtf_crd_rtn && (r_credits != c_CREDITS)) begin
            r_credits <= r_credits + c_CW'(1);
        end
    end

    // Sticky flags and saturating drop counter. An event in the same cycle as
    // a clear takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
            r_ovf_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_crd_err  <= 1'b0;
        end else begin
            if (w_drop_evt) begin
                if (stat_clr) begin
                    r_drop_cnt <= CNT_W'(1);
                end else if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                end
            end else if (stat_clr) begin
                r_drop_cnt <= '0;
            end

            if (w_ovf_evt) begin
                r_ovf_err <= 1'b1;
            end else if (stat_clr) begin
                r_ovf_err <= 1'b0;
            end

            if (w_frm_evt) begin
                r_frm_err <= 1'b1;
            end else if (stat_clr) begin
                r_frm_err <= 1'b0;
            end

            if (w_crd_evt) begin
                r_crd_err <= 1'b1;
            end else if (stat_clr) begin
                r_crd_err <= 1'b0;
            end
        end
    end

    assign mtf_fab_bus80 = r_fab_bus;
    assign mtf_drop_cnt  = r_drop_cnt;
    assign mtf_ovf_err   = r_ovf_err;
    assign mtf_frm_err   = r_frm_err;
    assign mtf_crd_err   = r_crd_err;

endmodule
`default_nettype wire

// File: tb/tb_mtf_add_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtf_add_fifo
// Brief    : Directed self-checking bench for mtf_add_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mtf_add_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [79:0] msf_mtf_fabbus80 = '0;
    logic [79:0] mtf_fab_bus80;
    logic        fab_mtf_crd_rtn = 1'b0;
    logic        stat_clr = 1'b0;
    logic [15:0] mtf_drop_cnt;
    logic        mtf_ovf_err;
    logic        mtf_frm_err;
    logic        mtf_crd_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [79:0] out_q [$];
    int          out_cyc [$];

    mtf_add_fifo #(
        .DEPTH   (16),
        .MAX_PKT (8),
        .CREDITS (8),
        .CNT_W   (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .msf_mtf_fabbus80 (msf_mtf_fabbus80),
        .mtf_fab_bus80    (mtf_fab_bus80),
        .fab_mtf_crd_rtn  (fab_mtf_crd_rtn),
        .stat_clr         (stat_clr),
        .mtf_drop_cnt     (mtf_drop_cnt),
        .mtf_ovf_err      (mtf_ovf_err),
        .mtf_frm_err      (mtf_frm_err),
        .mtf_crd_err      (mtf_crd_err)
    );

    always #5 clk = ~clk;

    // Cycle index, advanced on every rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every valid fabric word on the falling edge.
    always @(negedge clk) begin
        if (mtf_fab_bus80[79] === 1'b1) begin
            out_q.push_back(mtf_fab_bus80);
            out_cyc.push_back(cyc);
        end
    end

    function automatic logic [79:0] mkw(input bit sop, input bit eop,
                                        input logic [12:0] ctl, input logic [63:0] d);
        return {1'b1, sop, eop, ctl, d};
    endfunction

    // Present one input cycle, then return inputs to idle.
    task automatic drive(input logic [79:0] w, input bit rtn = 1'b0, input bit clr = 1'b0);
        msf_mtf_fabbus80 = w;
        fab_mtf_crd_rtn  = rtn;
        stat_clr         = clr;
        @(posedge clk);
        #1;
        msf_mtf_fabbus80 = '0;
        fab_mtf_crd_rtn  = 1'b0;
        stat_clr         = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rtn_n(input int n);
        repeat (n) drive(80'd0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        n_cmp++; if (mtf_fab_bus80 !== 80'd0) begin n_err++;
            $display("FAIL reset_bus: got %h expected 0", mtf_fab_bus80); end
        n_cmp++; if (mtf_drop_cnt !== 16'd0) begin n_err++;
            $display("FAIL reset_drop: got %0d expected 0", mtf_drop_cnt); end
        n_cmp++; if ({mtf_ovf_err, mtf_frm_err, mtf_crd_err} !== 3'b000) begin n_err++;
            $display("FAIL reset_flags: got %b expected 000", {mtf_ovf_err, mtf_frm_err, mtf_crd_err}); end
        rst_n = 1'b1;
        idle(1);
    endtask

    // 3-word packet; words leave one edge after the edge that follows their write.
    task automatic test_basic();
        logic [79:0] w [3];
        int base, wc;
        base = out_q.size();
        for (int i = 0; i < 3; i++) w[i] = mkw(i == 0, i == 2, 13'h100 + 13'(i), 64'hA0 + 64'(i));
        drive(w[0]);
        wc = cyc;
        drive(w[1]);
        drive(w[2]);
        idle(6);
        n_cmp++; if (out_q.size() - base !== 3) begin n_err++;
            $display("FAIL basic_count: got %0d expected 3", out_q.size() - base); end
        for (int i = 0; i < 3 && base + i < out_q.size(); i++) begin
            n_cmp++; if (out_q[base+i] !== w[i]) begin n_err++;
                $display("FAIL basic_data%0d: got %h expected %h", i, out_q[base+i], w[i]); end
            n_cmp++; if (out_cyc[base+i] !== wc + 1 + i) begin n_err++;
                $display("FAIL basic_lat%0d: got cycle %0d expected %0d", i, out_cyc[base+i], wc + 1 + i); end
        end
        // Counter is at 5, so three returns must not overflow it.
        rtn_n(3);
        idle(2);
        n_cmp++; if (mtf_crd_err !== 1'b0) begin n_err++;
            $display("FAIL basic_crd_err: got %b expected 0", mtf_crd_err); end
    endtask

    task automatic test_credit_exhaust();
        logic [79:0] p [10];
        int base;
        base = out_q.size();
        for (int i = 0; i < 10; i++) p[i] = mkw(1'b1, 1'b1, 13'h200 + 13'(i), 64'hB0 + 64'(i));
        for (int i = 0; i < 10; i++) drive(p[i]);
        idle(10);
        n_cmp++; if (out_q.size() - base !== 8) begin n_err++;
            $display("FAIL crd_count8: got %0d expected 8", out_q.size() - base); end
        for (int i = 0; i < 8 && base + i < out_q.size(); i++) begin
            n_cmp++; if (out_q[base+i] !== p[i]) begin n_err++;
                $display("FAIL crd_data%0d: got %h expected %h", i, out_q[base+i], p[i]); end
        end
        rtn_n(1);
        idle(4);
        n_cmp++; if (out_q.size() - base !== 9) begin n_err++;
            $display("FAIL crd_count9: got %0d expected 9", out_q.size() - base); end
        if (out_q.size() - base >= 9) begin
            n_cmp++; if (out_q[base+8] !== p[8]) begin n_err++;
                $display("FAIL crd_data8: got %h expected %h", out_q[base+8], p[8]); end
        end
        // Drain the last held word, then refill the counter to 8.
        rtn_n(1);
        idle(4);
        rtn_n(8);
        idle(2);
        n_cmp++; if (out_q.size() - base !== 10) begin n_err++;
            $display("FAIL crd_count10: got %0d expected 10", out_q.size() - base); end
        n_cmp++; if (mtf_crd_err !== 1'b0) begin n_err++;
            $display("FAIL crd_refill_err: got %b expected 0", mtf_crd_err); end
    endtask

    // Pkt A uses up all credits, B (8) and C (1) leave 9 queued, D (4) is dropped.
    task automatic test_drop();
        logic [79:0] b [9];
        logic [79:0] e [2];
        int base;
        base = out_q.size();
        for (int i = 0; i < 8; i++) drive(mkw(i == 0, i == 7, 13'h300, 64'hC0 + 64'(i)));
        idle(4);
        for (int i = 0; i < 8; i++) b[i] = mkw(i == 0, i == 7, 13'h310, 64'hD0 + 64'(i));
        b[8] = mkw(1'b1, 1'b1, 13'h320, 64'hDF);
        for (int i = 0; i < 9; i++) drive(b[i]);
        for (int i = 0; i < 4; i++) drive(mkw(i == 0, i == 3, 13'h330, 64'hEE0 + 64'(i)));
        idle(4);
        n_cmp++; if (out_q.size() - base !== 8) begin n_err++;
            $display("FAIL drop_held: got %0d words expected 8", out_q.size() - base); end
        n_cmp++; if (mtf_drop_cnt !== 16'd1) begin n_err++;
            $display("FAIL drop_cnt: got %0d expected 1", mtf_drop_cnt); end
        // 9 returns drain B and C, 8 more refill the counter.
        rtn_n(17);
        idle(4);
        n_cmp++; if (out_q.size() - base !== 17) begin n_err++;
            $display("FAIL drop_drain: got %0d words expected 17", out_q.size() - base); end
        for (int i = 0; i < 9 && base + 8 + i < out_q.size(); i++) begin
            n_cmp++; if (out_q[base+8+i] !== b[i]) begin n_err++;
                $display("FAIL drop_data%0d: got %h expected %h", i, out_q[base+8+i], b[i]); end
        end
        e[0] = mkw(1'b1, 1'b0, 13'h340, 64'hF0);
        e[1] = mkw(1'b0, 1'b1, 13'h341, 64'hF1);
        drive(e[0]);
        drive(e[1]);
        idle(5);
        n_cmp++; if (out_q.size() - base !== 19) begin n_err++;
            $display("FAIL drop_next: got %0d words expected 19", out_q.size() - base); end
        if (out_q.size() - base >= 19) begin
            n_cmp++; if (out_q[base+18] !== e[1]) begin n_err++;
                $display("FAIL drop_next_data: got %h expected %h", out_q[base+18], e[1]); end
        end
        n_cmp++; if (mtf_drop_cnt !== 16'd1 || mtf_crd_err !== 1'b0) begin n_err++;
            $display("FAIL drop_stats: got cnt %0d crd %b expected 1 0", mtf_drop_cnt, mtf_crd_err); end
    endtask

    task automatic test_overflow();
        logic [79:0] w [10];
        logic [79:0] f;
        int base;
        rtn_n(2);
        base = out_q.size();
        for (int i = 0; i < 10; i++) w[i] = mkw(i == 0, i == 9, 13'h400 + 13'(i), 64'h400 + 64'(i));
        for (int i = 0; i < 10; i++) drive(w[i]);
        idle(6);
        n_cmp++; if (out_q.size() - base !== 8) begin n_err++;
            $display("FAIL ovf_count: got %0d expected 8", out_q.size() - base); end
        for (int i = 0; i < 8 && base + i < out_q.size(); i++) begin
            n_cmp++; if (out_q[base+i] !== w[i]) begin n_err++;
                $display("FAIL ovf_data%0d: got %h expected %h", i, out_q[base+i], w[i]); end
        end
        n_cmp++; if (mtf_ovf_err !== 1'b1 || mtf_frm_err !== 1'b0) begin n_err++;
            $display("FAIL ovf_flags: got ovf %b frm %b expected 1 0", mtf_ovf_err, mtf_frm_err); end
        // A following sop packet must be accepted cleanly from IDLE.
        rtn_n(8);
        f = mkw(1'b1, 1'b1, 13'h4FF, 64'h4FF);
        drive(f);
        idle(4);
        n_cmp++; if (out_q.size() - base !== 9) begin n_err++;
            $display("FAIL ovf_idle_count: got %0d expected 9", out_q.size() - base); end
        if (out_q.size() - base >= 9) begin
            n_cmp++; if (out_q[base+8] !== f) begin n_err++;
                $display("FAIL ovf_idle_data: got %h expected %h", out_q[base+8], f); end
        end
        n_cmp++; if (mtf_frm_err !== 1'b0) begin n_err++;
            $display("FAIL ovf_idle_frm: got %b expected 0", mtf_frm_err); end
    endtask

    task automatic test_framing();
        logic [79:0] a, b;
        int base;
        drive(80'd0, 1'b0, 1'b1);
        n_cmp++; if (mtf_drop_cnt !== 16'd0 || mtf_ovf_err !== 1'b0) begin n_err++;
            $display("FAIL frm_clr1: got cnt %0d ovf %b expected 0 0", mtf_drop_cnt, mtf_ovf_err); end
        base = out_q.size();
        drive(mkw(1'b0, 1'b0, 13'h500, 64'h500));
        idle(3);
        n_cmp++; if (mtf_frm_err !== 1'b1) begin n_err++;
            $display("FAIL frm_nosop: got %b expected 1", mtf_frm_err); end
        n_cmp++; if (out_q.size() - base !== 0) begin n_err++;
            $display("FAIL frm_nosop_out: got %0d words expected 0", out_q.size() - base); end
        drive(80'd0, 1'b0, 1'b1);
        n_cmp++; if (mtf_frm_err !== 1'b0) begin n_err++;
            $display("FAIL frm_clr2: got %b expected 0", mtf_frm_err); end
        a = mkw(1'b1, 1'b0, 13'h510, 64'h510);
        b = mkw(1'b1, 1'b1, 13'h511, 64'h511);
        drive(a);
        drive(b);
        idle(4);
        n_cmp++; if (mtf_frm_err !== 1'b1) begin n_err++;
            $display("FAIL frm_sop_in_pkt: got %b expected 1", mtf_frm_err); end
        n_cmp++; if (out_q.size() - base !== 2) begin n_err++;
            $display("FAIL frm_pkt_count: got %0d expected 2", out_q.size() - base); end
        if (out_q.size() - base >= 2) begin
            n_cmp++; if (out_q[base] !== a || out_q[base+1] !== b) begin n_err++;
                $display("FAIL frm_pkt_data: got %h %h expected %h %h", out_q[base], out_q[base+1], a, b); end
        end
        drive(80'd0, 1'b0, 1'b1);
        // Error and clear in the same cycle: the error wins.
        drive(mkw(1'b0, 1'b1, 13'h520, 64'h520), 1'b0, 1'b1);
        n_cmp++; if (mtf_frm_err !== 1'b1) begin n_err++;
            $display("FAIL frm_clr_race: got %b expected 1", mtf_frm_err); end
        drive(80'd0, 1'b0, 1'b1);
        n_cmp++; if (mtf_frm_err !== 1'b0 || mtf_drop_cnt !== 16'd0) begin n_err++;
            $display("FAIL frm_clr3: got frm %b cnt %0d expected 0 0", mtf_frm_err, mtf_drop_cnt); end
    endtask

    task automatic test_crd_err_reset();
        logic [79:0] p [9];
        int base;
        // Counter is at 5 after the framing packets.
        rtn_n(3);
        idle(2);
        n_cmp++; if (mtf_crd_err !== 1'b0) begin n_err++;
            $display("FAIL crderr_at8: got %b expected 0", mtf_crd_err); end
        rtn_n(1);
        idle(1);
        n_cmp++; if (mtf_crd_err !== 1'b1) begin n_err++;
            $display("FAIL crderr_over: got %b expected 1", mtf_crd_err); end
        // Reset lands on the edge that would have popped the queued sop word.
        drive(mkw(1'b1, 1'b0, 13'h600, 64'h600));
        msf_mtf_fabbus80 = mkw(1'b0, 1'b0, 13'h601, 64'h601);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        msf_mtf_fabbus80 = '0;
        n_cmp++; if (mtf_fab_bus80[79] !== 1'b0) begin n_err++;
            $display("FAIL rst_bus_vld: got %b expected 0", mtf_fab_bus80[79]); end
        n_cmp++; if (mtf_crd_err !== 1'b0) begin n_err++;
            $display("FAIL rst_crd_err: got %b expected 0", mtf_crd_err); end
        idle(1);
        rst_n = 1'b1;
        base = out_q.size();
        drive(mkw(1'b0, 1'b1, 13'h602, 64'h602));
        idle(4);
        n_cmp++; if (mtf_frm_err !== 1'b1) begin n_err++;
            $display("FAIL rst_frm: got %b expected 1", mtf_frm_err); end
        n_cmp++; if (out_q.size() - base !== 0) begin n_err++;
            $display("FAIL rst_fifo_empty: got %0d words expected 0", out_q.size() - base); end
        for (int i = 0; i < 9; i++) p[i] = mkw(1'b1, 1'b1, 13'h610 + 13'(i), 64'h610 + 64'(i));
        for (int i = 0; i < 9; i++) drive(p[i]);
        idle(12);
        n_cmp++; if (out_q.size() - base !== 8) begin n_err++;
            $display("FAIL rst_credits: got %0d words expected 8", out_q.size() - base); end
        if (out_q.size() - base >= 8) begin
            n_cmp++; if (out_q[base] !== p[0] || out_q[base+7] !== p[7]) begin n_err++;
                $display("FAIL rst_data: got %h %h expected %h %h", out_q[base], out_q[base+7], p[0], p[7]); end
        end
    endtask

    initial begin
        idle(1);
        test_reset();
        test_basic();
        test_credit_exhaust();
        test_drop();
        test_overflow();
        test_framing();
        test_crd_err_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
